// File: rtl/mmio_button_reader.sv
`default_nettype none
// ============================================================================
// Module      : mmio_button_reader
// Description : Read-side responder for the memory-mapped button. Synchronises
//               and optionally debounces the pin (BUTTON_DEBOUNCE_EN), counts
//               presses (clear-on-read at BASE_ADDR), live level at BASE_ADDR+1.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_button_reader #(
    parameter logic [7:0] BASE_ADDR = 8'd254,
    parameter int         DB_CYCLES = 16,
    parameter int         CNT_SAT   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic       r_req,
    input  logic [7:0] addr,
    output logic [7:0] r_data,
    output logic       r_valid,
    output logic       btn_level
);

    localparam logic [7:0] c_lvl_addr = BASE_ADDR + 8'd1;
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_resp  = 1'b1;

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic       r_level_d;
    logic [7:0] r_press_cnt;
    logic [0:0] r_state;
    logic [7:0] r_rdata;
    logic       r_rvalid;

    logic       w_rise;
    logic       w_hit_cnt;
    logic       w_hit_lvl;
    logic [7:0] w_cnt_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
        end
    end

`ifdef BUTTON_DEBOUNCE_EN
    localparam logic [7:0] c_db_last = 8'(DB_CYCLES - 1);
    logic [7:0] r_db_cnt;

    // Level changes only after DB_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_db_cnt <= 8'd0;
            r_level  <= 1'b0;
        end else if (r_sync2 != r_level) begin
            if (r_db_cnt == c_db_last) begin
                r_level  <= r_sync2;
                r_db_cnt <= 8'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 8'd1;
            end
        end else begin
            r_db_cnt <= 8'd0;
        end
    end
`else
    logic [7:0] w_unused_db;
    assign w_unused_db = 8'(DB_CYCLES);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_level <= 1'b0;
        end else begin
            r_level <= r_sync2;
        end
    end
`endif

    assign w_rise    = r_level & ~r_level_d;
    assign w_hit_cnt = r_req && (addr == BASE_ADDR);
    assign w_hit_lvl = r_req && (addr == c_lvl_addr);
    assign w_cnt_inc = ((CNT_SAT != 0) && (r_press_cnt == 8'hFF)) ? 8'hFF
                                                                  : r_press_cnt + 8'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_level_d   <= 1'b0;
            r_press_cnt <= 8'd0;
            r_state     <= c_st_idle;
            r_rdata     <= 8'h00;
            r_rvalid    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            // A press landing on the clearing edge survives as a count of one.
            if ((r_state == c_st_idle) && w_hit_cnt) begin
                r_press_cnt <= {7'b0, w_rise};
            end else if (w_rise) begin
                r_press_cnt <= w_cnt_inc;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_hit_cnt) begin
                        r_state  <= c_st_resp;
                        r_rdata  <= r_press_cnt;
                        r_rvalid <= 1'b1;
                    end else if (w_hit_lvl) begin
                        r_state  <= c_st_resp;
                        r_rdata  <= {7'b0, r_level};
                        r_rvalid <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= c_st_idle;
                    r_rdata  <= 8'h00;
                    r_rvalid <= 1'b0;
                end
            endcase
        end
    end

    assign r_data    = r_rdata;
    assign r_valid   = r_rvalid;
    assign btn_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_mmio_button_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_button_reader
// Description : Directed self-checking bench; three instances cover saturating,
//               wrapping and BASE_ADDR=255 builds with shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_button_reader;

    localparam int c_db = 16;
`ifdef BUTTON_DEBOUNCE_EN
    localparam int c_wait_rise = c_db + 2;
`else
    localparam int c_wait_rise = 3;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       button = 1'b0;
    logic       r_req = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data_a, data_b, data_c;
    logic       valid_a, valid_b, valid_c;
    logic       lvl_a, lvl_b, lvl_c;

    int checks = 0;
    int failures = 0;

    logic [7:0] s_da, s_db, s_dc;
    logic       s_va, s_vb, s_vc;

    always #5 clock = ~clock;

    mmio_button_reader #(.BASE_ADDR(8'd254), .DB_CYCLES(c_db), .CNT_SAT(1)) u_dut_sat (
        .clock(clock), .reset(reset), .button(button), .r_req(r_req), .addr(addr),
        .r_data(data_a), .r_valid(valid_a), .btn_level(lvl_a));

    mmio_button_reader #(.BASE_ADDR(8'd254), .DB_CYCLES(c_db), .CNT_SAT(0)) u_dut_wrap (
        .clock(clock), .reset(reset), .button(button), .r_req(r_req), .addr(addr),
        .r_data(data_b), .r_valid(valid_b), .btn_level(lvl_b));

    mmio_button_reader #(.BASE_ADDR(8'd255), .DB_CYCLES(c_db), .CNT_SAT(1)) u_dut_top (
        .clock(clock), .reset(reset), .button(button), .r_req(r_req), .addr(addr),
        .r_data(data_c), .r_valid(valid_c), .btn_level(lvl_c));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            button = 1'b1;
            wait_cycles(hi);
            button = 1'b0;
            wait_cycles(lo);
        end
    endtask

    // Issues one request, snapshots the response cycle, then one idle cycle.
    task automatic do_read(input logic [7:0] a);
        addr  = a;
        r_req = 1'b1;
        tick();
        r_req = 1'b0;
        addr  = 8'h00;
        s_da = data_a; s_va = valid_a;
        s_db = data_b; s_vb = valid_b;
        s_dc = data_c; s_vc = valid_c;
        tick();
    endtask

    int pulses;

    initial begin
        wait_cycles(3);
        check_eq("rst_valid", {31'b0, valid_a}, 32'd0);
        check_eq("rst_data", {24'b0, data_a}, 32'h00);
        check_eq("rst_level", {31'b0, lvl_a}, 32'd0);
        reset = 1'b0;
        tick();

        do_read(8'd254);
        check_eq("first_rd_valid", {31'b0, s_va}, 32'd1);
        check_eq("first_rd_data", {24'b0, s_da}, 32'h00);
        check_eq("after_rd_valid", {31'b0, valid_a}, 32'd0);
        check_eq("after_rd_data", {24'b0, data_a}, 32'h00);

        press(3, 40, 40);
        do_read(8'd254);
        check_eq("three_sat", {24'b0, s_da}, 32'h03);
        check_eq("three_wrap", {24'b0, s_db}, 32'h03);
        do_read(8'd254);
        check_eq("cleared", {24'b0, s_da}, 32'h00);

        button = 1'b1;
        wait_cycles(40);
        check_eq("level_hi", {31'b0, lvl_a}, 32'd1);
        do_read(8'd255);
        check_eq("lvl_rd_valid", {31'b0, s_va}, 32'd1);
        check_eq("lvl_rd_hi", {24'b0, s_da}, 32'h01);
        button = 1'b0;
        wait_cycles(50);
        do_read(8'd255);
        check_eq("lvl_rd_lo", {24'b0, s_da}, 32'h00);
        do_read(8'd254);
        check_eq("lvl_no_clear", {24'b0, s_da}, 32'h01);

        // Rising edge of the level lands exactly on the accepting edge.
        press(5, 40, 40);
        button = 1'b1;
        wait_cycles(c_wait_rise);
        do_read(8'd254);
        check_eq("coinc_sat", {24'b0, s_da}, 32'h05);
        check_eq("coinc_wrap", {24'b0, s_db}, 32'h05);
        do_read(8'd254);
        check_eq("coinc_kept", {24'b0, s_da}, 32'h01);

        wait_cycles(30);
        do_read(8'd0);
        check_eq("wrap_addr_valid", {31'b0, s_vc}, 32'd1);
        check_eq("wrap_addr_data", {24'b0, s_dc}, 32'h01);
        check_eq("wrap_addr_other", {31'b0, s_va}, 32'd0);
        button = 1'b0;
        wait_cycles(40);
        do_read(8'd254);
        check_eq("post_coinc", {24'b0, s_da}, 32'h00);

        press(300, 20, 20);
        do_read(8'd254);
        check_eq("sat_300", {24'b0, s_da}, 32'hFF);
        check_eq("wrap_300", {24'b0, s_db}, 32'h2C);
        press(257, 20, 20);
        do_read(8'd254);
        check_eq("sat_257", {24'b0, s_da}, 32'hFF);
        check_eq("wrap_257", {24'b0, s_db}, 32'h01);

        pulses = 0;
        addr   = 8'd254;
        r_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid_a) pulses++;
        end
        r_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (valid_a) pulses++;
        end
        check_eq("held_req_pulses", pulses, 32'd2);

        pulses = 0;
        addr   = 8'h10;
        r_req  = 1'b1;
        tick();
        r_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (valid_a || data_a != 8'h00) pulses++;
            tick();
        end
        check_eq("unmatched", pulses, 32'd0);

        addr  = 8'd254;
        r_req = 1'b1;
        tick();
        r_req = 1'b0;
        check_eq("pre_reset_valid", {31'b0, valid_a}, 32'd1);
        reset = 1'b1;
        tick();
        check_eq("reset_in_resp", {31'b0, valid_a}, 32'd0);
        check_eq("reset_in_resp_d", {24'b0, data_a}, 32'h00);
        reset = 1'b0;
        tick();

`ifdef BUTTON_DEBOUNCE_EN
        press(1, 10, 40);
        do_read(8'd254);
        check_eq("glitch_10", {24'b0, s_da}, 32'h00);
        press(1, 20, 40);
        do_read(8'd254);
        check_eq("pulse_20", {24'b0, s_da}, 32'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_button_reader.md
Name: mmio_button_reader

Overview:
- Read-side responder for the memory-mapped button peripheral.
- Synchronises the raw board button, optionally debounces it, and counts presses.
- Answers core load requests at BASE_ADDR (press count, clear-on-read) and BASE_ADDR+1 (live level) with a one-cycle-latency data/valid handshake.
- Sits between the board pin and the core's 8-bit data bus, beside the writer-side register logic.

Parameters:
- BASE_ADDR, 8'd254, address of press-count register; level register at BASE_ADDR+1 modulo 256.
- DB_CYCLES, 16, consecutive stable cycles required to accept a level change (debounce builds only); legal range 1..255.
- CNT_SAT, 1, 1 = press counter saturates at 255; 0 = wraps 255 -> 0.

Ports:
- clock  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- button  input  1  raw asynchronous button pin, active-high
- r_req  input  1  core read request, sampled on posedge
- addr  input  8  core read address, valid with r_req
- r_data  output  8  read data, valid only while r_valid=1, else 8'h00
- r_valid  output  1  one-cycle pulse marking r_data valid
- btn_level  output  1  current accepted button level, for status LEDs

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset: sync flops=0, btn_level=0, debounce counter=0, press_cnt=0, FSM=IDLE, r_valid=0, r_data=8'h00. Reset asserted mid-response drops r_valid on the next edge; the request is lost.
- Input path: 2-flop synchroniser gives btn_sync, so btn_sync lags button by 2 cycles.
- Without debounce: btn_level follows btn_sync with 1 further cycle.
- Rising-edge detect: btn_level 0->1 registered edge increments press_cnt by 1, in the cycle after btn_level rises.
- press_cnt at 255: stays 255 if CNT_SAT=1; becomes 0 if CNT_SAT=0.
- FSM IDLE: on posedge, if r_req=1 and addr is BASE_ADDR or BASE_ADDR+1, go to RESP.
  - Latch data: press_cnt for BASE_ADDR; {7'b0, btn_level} for BASE_ADDR+1.
- FSM RESP: r_valid=1 and r_data=latched value for exactly one cycle, then return to IDLE.
  - r_req seen while in RESP is ignored, not queued. Back-to-back reads therefore need r_req in alternate cycles; max throughput 1 read per 2 cycles.
- Unmatched address: no state change, r_valid stays 0, r_data stays 8'h00.
- Clear-on-read: an accepted BASE_ADDR read clears press_cnt on the same edge that latches it.
  - r_data returns the pre-clear value.
  - If a press edge coincides with that edge, press_cnt becomes 1; the press is never lost.
- BASE_ADDR+1 reads never modify press_cnt.
- BASE_ADDR=255: level register maps to 0 (wrap); the decode must compare modulo 256.
- Latency: r_req accepted at edge N -> r_valid high in cycle N+1.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_EN.
- Defined: an 8-bit counter runs while btn_sync != btn_level and resets to 0 on any cycle they agree.
  - When the counter reaches DB_CYCLES-1 with the mismatch still present, btn_level takes btn_sync and the counter clears.
  - Glitches shorter than DB_CYCLES cycles never reach btn_level or press_cnt.
  - Press-to-count latency is DB_CYCLES+3 cycles.
- Undefined: no counter is instantiated; btn_level follows btn_sync directly (latency above); DB_CYCLES is unused.

Test Plan:
- Reset, then read BASE_ADDR (254) -> r_valid pulse 1 cycle after request, r_data=8'h00; r_data=8'h00 in all other cycles.
- Three clean presses (each held 40 cycles, released 40), then read 254 -> r_data=8'h03; immediate second read -> 8'h00.
- Hold button high, read 255 -> r_data=8'h01; release, wait 50 cycles, read 255 -> 8'h00; press_cnt unchanged by these reads.
- CNT_SAT=1, 300 presses, read 254 -> 8'hFF.
- CNT_SAT=0, 257 presses -> 8'h01.
- Press edge on the same edge as an accepted 254 read with press_cnt=5 -> r_data=8'h05; next read -> 8'h01.
- BUTTON_DEBOUNCE_EN, DB_CYCLES=16: a 10-cycle pulse -> count stays 0; a 20-cycle pulse -> count 1.
- r_req held high 4 cycles at addr 254 -> exactly 2 r_valid pulses.
- addr 8'h10 -> no pulse.
- reset during RESP -> r_valid 0 next cycle.
